// File: rtl/apx_div_pkg.sv
// Shared types and constants for the sequential signed divider.
package apx_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Counter width able to hold 0..w
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam logic [63:0] QUOT_DIV0 = '1;

endpackage

// File: rtl/apx_div_step.sv
// One radix-2 restoring iteration: shift in a dividend bit, compare, subtract.
module apx_div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  assign shifted  = {rem, bit_in};
  // rem < divisor on entry, so the true difference always fits in WIDTH bits
  assign diff     = shifted[WIDTH-1:0] - divisor;
  assign q_bit    = (shifted >= {1'b0, divisor});
  assign rem_next = q_bit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/apx_seq_divider.sv
// Sequential signed divider, one quotient bit per cycle with start/done handshake.
// Define APX_DIV_TRUNC_EN to skip the low APX_BITS quotient bits and drop the remainder.
module apx_seq_divider
  import apx_div_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned APX_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] input_A,
  input  logic [WIDTH-1:0] input_B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero
);

`ifdef APX_DIV_TRUNC_EN
  localparam bit APX_EN = 1'b1;
`else
  localparam bit APX_EN = 1'b0;
`endif

  localparam int unsigned SKIP = APX_EN ? APX_BITS : 0;
  localparam int unsigned N    = WIDTH - SKIP;
  localparam int unsigned CW   = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] Q_DIV0   = QUOT_DIV0[WIDTH-1:0];

  state_t           state, state_d;
  logic [WIDTH-1:0] dvd, dvd_d;
  logic [WIDTH-1:0] dvs, dvs_d;
  logic [WIDTH-1:0] rem, rem_d;
  logic [WIDTH-1:0] quo, quo_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             sign_q, sign_q_d;
  logic             sign_r, sign_r_d;
  logic             special, special_d;
  logic             dz, dz_d;
  logic             busy_d, done_d, dbz_d;
  logic [WIDTH-1:0] q_d, r_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] qmag, rmag;

  assign a_mag = input_A[WIDTH-1] ? (~input_A + WIDTH'(1)) : input_A;
  assign b_mag = input_B[WIDTH-1] ? (~input_B + WIDTH'(1)) : input_B;

  // Skipped low quotient bits come out as zeros after the final shift
  assign qmag = quo << SKIP;
  assign rmag = APX_EN ? '0 : rem;

  apx_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .bit_in   (dvd[WIDTH-1]),
    .divisor  (dvs),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      quo         <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      special     <= 1'b0;
      dz          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_d;
      dvd         <= dvd_d;
      dvs         <= dvs_d;
      rem         <= rem_d;
      quo         <= quo_d;
      cnt         <= cnt_d;
      sign_q      <= sign_q_d;
      sign_r      <= sign_r_d;
      special     <= special_d;
      dz          <= dz_d;
      busy        <= busy_d;
      done        <= done_d;
      Q           <= q_d;
      R           <= r_d;
      div_by_zero <= dbz_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state;
    dvd_d     = dvd;
    dvs_d     = dvs;
    rem_d     = rem;
    quo_d     = quo;
    cnt_d     = cnt;
    sign_q_d  = sign_q;
    sign_r_d  = sign_r;
    special_d = special;
    dz_d      = dz;
    busy_d    = busy;
    done_d    = 1'b0;
    q_d       = Q;
    r_d       = R;
    dbz_d     = div_by_zero;

    case (state)
      IDLE: begin
        if (start) begin
          busy_d    = 1'b1;
          dvd_d     = a_mag;
          dvs_d     = b_mag;
          rem_d     = '0;
          quo_d     = '0;
          cnt_d     = '0;
          sign_q_d  = input_A[WIDTH-1] ^ input_B[WIDTH-1];
          sign_r_d  = input_A[WIDTH-1];
          special_d = 1'b0;
          dz_d      = 1'b0;
          state_d   = ITER;
          // Special cases carry the final signed result straight to FIX
          if (input_B == '0) begin
            quo_d     = Q_DIV0;
            rem_d     = input_A;
            special_d = 1'b1;
            dz_d      = 1'b1;
            state_d   = FIX;
          end else if ((input_A == MOST_NEG) && (input_B == '1)) begin
            quo_d     = input_A;
            rem_d     = '0;
            special_d = 1'b1;
            state_d   = FIX;
          end
        end
      end
      ITER: begin
        dvd_d = dvd << 1;
        rem_d = step_rem;
        quo_d = {quo[WIDTH-2:0], step_q};
        cnt_d = cnt + CW'(1);
        if (cnt == CW'(N - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dbz_d   = dz;
        if (special) begin
          q_d = quo;
          r_d = rem;
        end else begin
          q_d = sign_q ? (~qmag + WIDTH'(1)) : qmag;
          r_d = sign_r ? (~rmag + WIDTH'(1)) : rmag;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
